// File: rtl/operand_entry_rf.sv
// Keypad operand entry: BCD digit buffer (key/backspace/clear) committed as binary into NREG registers.
// Entry state and pulses update one cycle after the event, read ports have 1-cycle latency; no backpressure, one event per cycle.
module operand_entry_rf #(
  parameter  int NREG   = 2,
  parameter  int DIGITS = 4,
  parameter  int WIDTH  = 16,
  localparam int AW     = $clog2(NREG),
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  KEY_VALID,
  input  logic [3:0]            KEY_DIGIT,
  input  logic                  BKSP,
  input  logic                  CLR,
  input  logic                  WE,
  input  logic [AW-1:0]         WADDR,
  input  logic [AW-1:0]         RADDR_1,
  input  logic [AW-1:0]         RADDR_2,
  output logic [WIDTH-1:0]      Dout_1,
  output logic [WIDTH-1:0]      Dout_2,
  output logic [4*DIGITS-1:0]   DIS,
  output logic [CW-1:0]         DIG_CNT,
  output logic                  FULL,
  output logic                  WR_DONE,
  output logic                  ERR
);

  function automatic longint unsigned max_entry(input int d);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < d; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam longint unsigned MAX_ENTRY = max_entry(DIGITS);

  generate
    if (NREG < 2 || DIGITS < 1 || DIGITS > 9 ||
        (WIDTH < 64 && MAX_ENTRY >= (64'd1 << WIDTH))) begin : g_bad_params
      $error("operand_entry_rf: illegal NREG/DIGITS/WIDTH combination");
    end
  endgenerate

  logic [WIDTH-1:0]    rf_q [NREG];
  logic [WIDTH-1:0]    rf_d [NREG];
  logic [4*DIGITS-1:0] ent_q, ent_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                wr_done_q, wr_done_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    dout1_q, dout1_d;
  logic [WIDTH-1:0]    dout2_q, dout2_d;
  logic [WIDTH-1:0]    bin;
  logic                waddr_ok;

  // Horner: acc = acc*10 + digit, most significant digit first
  always_comb begin
    bin = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      bin = (bin << 3) + (bin << 1) + WIDTH'(ent_q[4*i +: 4]);
    end
  end

  always_comb begin
    waddr_ok = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (WADDR == AW'(i)) waddr_ok = 1'b1;
    end
  end

  always_comb begin
    rf_d      = rf_q;
    ent_d     = ent_q;
    cnt_d     = cnt_q;
    wr_done_d = 1'b0;
    err_d     = 1'b0;
    if (CLR) begin
      ent_d = '0;
      cnt_d = '0;
    end else if (WE) begin
      if (waddr_ok) begin
        for (int i = 0; i < NREG; i++) begin
          if (WADDR == AW'(i)) rf_d[i] = bin;
        end
        ent_d     = '0;
        cnt_d     = '0;
        wr_done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (BKSP) begin
      if (cnt_q != '0) begin
        ent_d = ent_q >> 4;
        cnt_d = cnt_q - CW'(1);
      end
    end else if (KEY_VALID) begin
      if (KEY_DIGIT > 4'd9) begin
        err_d = 1'b1;
      end else if (cnt_q == '0 && KEY_DIGIT == 4'd0) begin
        // leading zero: accepted but leaves the buffer empty
        ent_d = ent_q;
      end else if (full_q) begin
        err_d = 1'b1;
      end else begin
        ent_d      = ent_q << 4;
        ent_d[3:0] = KEY_DIGIT;
        cnt_d      = cnt_q + CW'(1);
      end
    end
    full_d = (cnt_d == CW'(DIGITS));
  end

  // Reads sample the pre-write array, so same-cycle read/write returns the old value
  always_comb begin
    dout1_d = '0;
    dout2_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (RADDR_1 == AW'(i)) dout1_d = rf_q[i];
      if (RADDR_2 == AW'(i)) dout2_d = rf_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rf_q      <= '{default: '0};
      ent_q     <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      dout1_q   <= '0;
      dout2_q   <= '0;
    end else begin
      rf_q      <= rf_d;
      ent_q     <= ent_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
      dout1_q   <= dout1_d;
      dout2_q   <= dout2_d;
    end
  end

  assign Dout_1  = dout1_q;
  assign Dout_2  = dout2_q;
  assign DIS     = ent_q;
  assign DIG_CNT = cnt_q;
  assign FULL    = full_q;
  assign WR_DONE = wr_done_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_operand_entry_rf.sv
// Directed bench for operand_entry_rf at NREG=3, DIGITS=4, WIDTH=16.
module tb_operand_entry_rf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        bksp;
  logic        clr;
  logic        we;
  logic [1:0]  waddr;
  logic [1:0]  raddr_1;
  logic [1:0]  raddr_2;
  logic [15:0] dout_1;
  logic [15:0] dout_2;
  logic [15:0] dis;
  logic [2:0]  dig_cnt;
  logic        full;
  logic        wr_done;
  logic        err;

  int errors = 0;
  int checks = 0;

  operand_entry_rf #(.NREG(3), .DIGITS(4), .WIDTH(16)) dut (
    .CLK(clk), .RST_N(rst_n), .KEY_VALID(key_valid), .KEY_DIGIT(key_digit),
    .BKSP(bksp), .CLR(clr), .WE(we), .WADDR(waddr),
    .RADDR_1(raddr_1), .RADDR_2(raddr_2), .Dout_1(dout_1), .Dout_2(dout_2),
    .DIS(dis), .DIG_CNT(dig_cnt), .FULL(full), .WR_DONE(wr_done), .ERR(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    key_valid = 1'b0;
    bksp      = 1'b0;
    clr       = 1'b0;
    we        = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b1; key_digit = 4'd5; we = 1'b1;
    tick(); tick();
    idle();
    checks++; if (dis !== 16'h0) begin errors++; $display("FAIL reset_dis: got %h want 0000", dis); end
    checks++; if (dig_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dig_cnt); end
    checks++; if ({full, wr_done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {full, wr_done, err}); end
    checks++; if (dout_1 !== 16'd0 || dout_2 !== 16'd0) begin errors++; $display("FAIL reset_dout: got %0d/%0d want 0/0", dout_1, dout_2); end
    rst_n = 1'b1;
  endtask

  task automatic test_entry_commit();
    key(4'd1);
    checks++; if (dis !== 16'h0001 || dig_cnt !== 3'd1) begin errors++; $display("FAIL key1: got %h/%0d want 0001/1", dis, dig_cnt); end
    key(4'd2); key(4'd3);
    checks++; if (dis !== 16'h0123 || dig_cnt !== 3'd3) begin errors++; $display("FAIL keys123: got %h/%0d want 0123/3", dis, dig_cnt); end
    checks++; if (full !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL keys123_flags: full=%b err=%b want 0 0", full, err); end
    raddr_2 = 2'd1; we = 1'b1; waddr = 2'd1;
    tick(); idle();
    checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL commit_done: got %b want 1", wr_done); end
    checks++; if (dis !== 16'h0 || dig_cnt !== 3'd0) begin errors++; $display("FAIL commit_clear: got %h/%0d want 0000/0", dis, dig_cnt); end
    checks++; if (dout_2 !== 16'd0) begin errors++; $display("FAIL commit_old_read: got %0d want 0", dout_2); end
    tick();
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL commit_pulse_end: got %b want 0", wr_done); end
    checks++; if (dout_2 !== 16'd123) begin errors++; $display("FAIL commit_read: got %0d want 123", dout_2); end
  endtask

  task automatic test_leading_zero();
    key(4'd0);
    checks++; if (dig_cnt !== 3'd0 || err !== 1'b0 || dis !== 16'h0) begin errors++; $display("FAIL lead_zero: got %h/%0d err=%b want 0000/0 0", dis, dig_cnt, err); end
    key(4'd0); key(4'd7);
    checks++; if (dis !== 16'h0007 || dig_cnt !== 3'd1) begin errors++; $display("FAIL keys007: got %h/%0d want 0007/1", dis, dig_cnt); end
    bksp = 1'b1; tick(); idle();
    checks++; if (dis !== 16'h0 || dig_cnt !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL bksp1: got %h/%0d err=%b want 0000/0 0", dis, dig_cnt, err); end
    bksp = 1'b1; tick(); idle();
    checks++; if (dig_cnt !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL bksp_empty: got %0d err=%b want 0 0", dig_cnt, err); end
  endtask

  task automatic test_full();
    key(4'd9); key(4'd9); key(4'd9);
    checks++; if (full !== 1'b0 || dig_cnt !== 3'd3) begin errors++; $display("FAIL three9: full=%b cnt=%0d want 0 3", full, dig_cnt); end
    key(4'd9);
    checks++; if (full !== 1'b1 || dig_cnt !== 3'd4 || dis !== 16'h9999) begin errors++; $display("FAIL four9: full=%b cnt=%0d dis=%h want 1 4 9999", full, dig_cnt, dis); end
    key(4'd5);
    checks++; if (err !== 1'b1 || dis !== 16'h9999 || dig_cnt !== 3'd4) begin errors++; $display("FAIL overflow_key: err=%b dis=%h cnt=%0d want 1 9999 4", err, dis, dig_cnt); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_end: got %b want 0", err); end
    raddr_1 = 2'd0; we = 1'b1; waddr = 2'd0;
    tick(); idle();
    checks++; if (wr_done !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL commit9999: wr_done=%b full=%b want 1 0", wr_done, full); end
    tick();
    checks++; if (dout_1 !== 16'd9999) begin errors++; $display("FAIL read9999: got %0d want 9999", dout_1); end
  endtask

  task automatic test_reject();
    key(4'd4);
    key_valid = 1'b1; key_digit = 4'hA; tick(); idle();
    checks++; if (err !== 1'b1 || dis !== 16'h0004 || dig_cnt !== 3'd1) begin errors++; $display("FAIL bad_digit: err=%b dis=%h cnt=%0d want 1 0004 1", err, dis, dig_cnt); end
    we = 1'b1; waddr = 2'd3; tick(); idle();
    checks++; if (err !== 1'b1 || wr_done !== 1'b0 || dis !== 16'h0004) begin errors++; $display("FAIL bad_waddr: err=%b wr_done=%b dis=%h want 1 0 0004", err, wr_done, dis); end
    raddr_1 = 2'd3; raddr_2 = 2'd2; tick();
    checks++; if (dout_1 !== 16'd0 || dout_2 !== 16'd0) begin errors++; $display("FAIL oob_read: got %0d/%0d want 0/0", dout_1, dout_2); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_waddr_pulse_end: got %b want 0", err); end
    raddr_1 = 2'd0; raddr_2 = 2'd1; tick();
    checks++; if (dout_1 !== 16'd9999 || dout_2 !== 16'd123) begin errors++; $display("FAIL rf_kept: got %0d/%0d want 9999/123", dout_1, dout_2); end
  endtask

  task automatic test_priority();
    key_valid = 1'b1; key_digit = 4'd5; clr = 1'b1; tick(); idle();
    checks++; if (dis !== 16'h0 || dig_cnt !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL clr_over_key: dis=%h cnt=%0d err=%b want 0000 0 0", dis, dig_cnt, err); end
    key(4'd6);
    raddr_1 = 2'd2; we = 1'b1; waddr = 2'd2; key_valid = 1'b1; key_digit = 4'd7;
    tick(); idle();
    checks++; if (wr_done !== 1'b1 || dis !== 16'h0 || dig_cnt !== 3'd0) begin errors++; $display("FAIL we_over_key: wr_done=%b dis=%h cnt=%0d want 1 0000 0", wr_done, dis, dig_cnt); end
    tick();
    checks++; if (dout_1 !== 16'd6) begin errors++; $display("FAIL we_over_key_read: got %0d want 6", dout_1); end
    key(4'd3);
    bksp = 1'b1; key_valid = 1'b1; key_digit = 4'd8; tick(); idle();
    checks++; if (dis !== 16'h0 || dig_cnt !== 3'd0) begin errors++; $display("FAIL bksp_over_key: dis=%h cnt=%0d want 0000 0", dis, dig_cnt); end
    key(4'd5);
    clr = 1'b1; we = 1'b1; waddr = 2'd2; tick(); idle();
    checks++; if (wr_done !== 1'b0 || dis !== 16'h0) begin errors++; $display("FAIL clr_over_we: wr_done=%b dis=%h want 0 0000", wr_done, dis); end
    tick();
    checks++; if (dout_1 !== 16'd6) begin errors++; $display("FAIL clr_over_we_read: got %0d want 6", dout_1); end
  endtask

  task automatic test_same_addr();
    key(4'd8);
    we = 1'b1; waddr = 2'd2; tick(); idle();
    checks++; if (dout_1 !== 16'd6) begin errors++; $display("FAIL rw_same_old: got %0d want 6", dout_1); end
    tick();
    checks++; if (dout_1 !== 16'd8) begin errors++; $display("FAIL rw_same_new: got %0d want 8", dout_1); end
  endtask

  task automatic test_reset_commit();
    key(4'd4); key(4'd2);
    checks++; if (dis !== 16'h0042 || dig_cnt !== 3'd2) begin errors++; $display("FAIL keys42: got %h/%0d want 0042/2", dis, dig_cnt); end
    raddr_1 = 2'd2; raddr_2 = 2'd0; we = 1'b1; waddr = 2'd2; rst_n = 1'b0;
    tick(); idle(); rst_n = 1'b1;
    checks++; if (dis !== 16'h0 || dig_cnt !== 3'd0 || {full, wr_done, err} !== 3'b000) begin errors++; $display("FAIL rst_commit_state: dis=%h cnt=%0d flags=%b want 0000 0 000", dis, dig_cnt, {full, wr_done, err}); end
    checks++; if (dout_1 !== 16'd0 || dout_2 !== 16'd0) begin errors++; $display("FAIL rst_commit_dout: got %0d/%0d want 0/0", dout_1, dout_2); end
    tick();
    checks++; if (dout_1 !== 16'd0 || dout_2 !== 16'd0) begin errors++; $display("FAIL rst_commit_rf: got %0d/%0d want 0/0", dout_1, dout_2); end
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_digit = 4'd0; bksp = 1'b0; clr = 1'b0;
    we = 1'b0; waddr = 2'd0; raddr_1 = 2'd0; raddr_2 = 2'd0;
    test_reset();
    test_entry_commit();
    test_leading_zero();
    test_full();
    test_reject();
    test_priority();
    test_same_addr();
    test_reset_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
